reg_file_wb: RTL and testbench
==============================

Name: reg_file_wb

Overview:
- 32 x 32-bit general-purpose register file for the single-cycle CPU.
- Sits at the consumer end of the write-back select path. It receives the destination register index chosen by the RegDst select and the write-back data chosen by the MemtoReg select.
- It decodes that index into 32 per-register write enables, which is the inverse of an N-to-1 select.
- Provides two combinational read ports (rs, rt) and a debug read port.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register index width; depth = 2**ADDR_W.
- BYPASS, 1, 1 = same-cycle write-to-read forwarding on the read ports; 0 = read returns the stored value.
- RESET_VAL, 0, value loaded into registers 1..31 on reset.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- RegWr, input, 1, write enable from the control unit.
- rw, input, ADDR_W, destination register index (from the RegDst select).
- busW, input, DATA_W, write-back data.
- ra, input, ADDR_W, read port A index (rs).
- rb, input, ADDR_W, read port B index (rt).
- busA, output, DATA_W, read data A.
- busB, output, DATA_W, read data B.
- dbg_addr, input, ADDR_W, debug/testbench read index.
- dbg_data, output, DATA_W, debug read data. Never bypassed.
- wr_count, output, 32, number of committed writes since reset. Wraps at 2**32.

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (rst_n).
- Reset:
  - While rst_n = 0, regs 1..31 = RESET_VAL and wr_count = 0, independent of clk.
  - busA, busB and dbg_data reflect the reset contents combinationally: RESET_VAL, or 0 for index 0.
  - Deassertion takes effect at the next rising edge; no write is committed on the edge where rst_n is still low.
  - Reset mid-operation discards any write presented in that cycle.
- Register 0:
  - Hardwired 0. Reads of index 0 return 0 on every port, including under bypass.
  - Writes to index 0 are dropped and do not increment wr_count.
- Write decode:
  - One-hot enable vector: wen[i] = RegWr && (rw == i), for i = 1..31.
  - At most one bit is set.
- Write timing:
  - On a rising clk edge with rst_n = 1 and wen[i] = 1, reg[i] <= busW.
  - The value is visible on dbg_data and non-bypassed reads after that edge, i.e. 1-cycle latency.
- wr_count: increments by 1 on every edge that commits a write, meaning RegWr = 1 and rw != 0. Unsigned, modulo 2**32.
- Reads: combinational, zero latency. busA = reg[ra], busB = reg[rb], dbg_data = reg[dbg_addr].
- Bypass (BYPASS = 1):
  - If RegWr = 1, rw != 0 and ra == rw, then busA = busW in the same cycle. Same rule for busB.
  - Both ports may bypass at once when ra == rb == rw.
  - BYPASS = 0: reads return the pre-edge stored value until the edge commits.
- Simultaneous events: a write and reads of the same register in one cycle follow the bypass rule above. There is no other contention, since there is a single write port.
- X handling: if RegWr is X, no register may be silently corrupted in simulation; the model flags an assertion error.

Decomposition:
- Shared package (cpu_pkg): REG_ZERO = 5'd0, DATA_W and ADDR_W constants, and the reg_idx_t typedef. These are reused by the RegDst select and the control unit.
- One sub-module: wr_decoder_5_32.
  - Purely combinational ADDR_W-to-2**ADDR_W one-hot decoder with enable input; bit 0 is forced to 0.
  - The storage array, bypass logic and wr_count stay in reg_file_wb.

Test Plan:
1. Reset and zero register: rst_n = 0 for 2 cycles, then 1. All dbg_data reads for 0..31 return 0 and wr_count = 0. Then RegWr = 1, rw = 0, busW = 32'hDEADBEEF for one edge: reg 0 still reads 0 and wr_count stays 0.
2. Basic write/read: write rw = 5, busW = 32'h12345678, then rw = 31, busW = 32'hFFFFFFFF. Next cycle, ra = 5 and rb = 31 give busA = 32'h12345678 and busB = 32'hFFFFFFFF, with wr_count = 2.
3. Bypass: BYPASS = 1, reg 8 holds 32'h1. In one cycle set RegWr = 1, rw = 8, busW = 32'hA5A5A5A5, ra = rb = 8. busA = busB = 32'hA5A5A5A5 before the edge, while dbg_data(8) = 32'h1 until the edge. Repeat with BYPASS = 0: busA = 32'h1 until the edge.
4. Write-enable gating: RegWr = 0, rw = 3, busW = 32'h55 for 4 edges. Reg 3 is unchanged and wr_count is unchanged.
5. Async reset mid-operation: write reg 10 = 32'h77, then drop rst_n between clock edges while RegWr = 1, rw = 10, busW = 32'h99. Reg 10 reads 0 immediately, without waiting for an edge, and wr_count = 0. After release, the next write commits normally.
6. Exhaustive decode: write value i + 32'h100 to each i = 1..31 in sequence, then read all via dbg_addr. Each reg i = i + 32'h100 (no aliasing) and wr_count = 31.

Source files
------------

// File: rtl/reg_file_wb_pkg.sv
// Shared CPU package: datapath widths, the register index type and the
// hardwired-zero register index. Reused by the RegDst select, the control
// unit and the register file.
package cpu_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  typedef logic [ADDR_W-1:0] reg_idx_t;

  localparam reg_idx_t REG_ZERO = 5'd0;
endpackage

// File: rtl/reg_file_wb_if.sv
// Register-file bus interface: write-back port, two read ports, debug read
// port and the committed-write counter.
//   master : CPU datapath / testbench side (drives indices and write data)
//   slave  : register file side (returns read data and wr_count)
interface reg_file_wb_if #(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int ADDR_W = cpu_pkg::ADDR_W
);
  logic              RegWr;
  logic [ADDR_W-1:0] rw;
  logic [DATA_W-1:0] busW;
  logic [ADDR_W-1:0] ra;
  logic [ADDR_W-1:0] rb;
  logic [DATA_W-1:0] busA;
  logic [DATA_W-1:0] busB;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_data;
  logic [31:0]       wr_count;

  modport master (
    output RegWr, rw, busW, ra, rb, dbg_addr,
    input  busA, busB, dbg_data, wr_count
  );

  modport slave (
    input  RegWr, rw, busW, ra, rb, dbg_addr,
    output busA, busB, dbg_data, wr_count
  );
endinterface

// File: rtl/reg_file_wb_wr_decoder.sv
// wr_decoder_5_32: combinational ADDR_W-to-2**ADDR_W one-hot decoder with
// enable. Output bit 0 is tied low so register 0 can never be written.
//   en  : decode enable (RegWr)
//   idx : destination register index (rw)
//   wen : one-hot per-register write enables
module wr_decoder_5_32 #(
  parameter int ADDR_W = cpu_pkg::ADDR_W
) (
  input  logic                 en,
  input  logic [ADDR_W-1:0]    idx,
  output logic [2**ADDR_W-1:0] wen
);
  localparam int DEPTH = 2**ADDR_W;

  assign wen[0] = 1'b0;

  for (genvar gi = 1; gi < DEPTH; gi++) begin : g_dec
    assign wen[gi] = en && (idx == ADDR_W'(gi));
  end
endmodule

// File: rtl/reg_file_wb.sv
// reg_file_wb: 32 x 32-bit register file with write-back decode, optional
// same-cycle write-to-read forwarding and a committed-write counter.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : reg_file_wb_if.slave (RegWr/rw/busW write port, ra/rb -> busA/busB
//           read ports, dbg_addr -> dbg_data debug port, wr_count)
module reg_file_wb #(
  parameter int                DATA_W    = cpu_pkg::DATA_W,
  parameter int                ADDR_W    = cpu_pkg::ADDR_W,
  parameter bit                BYPASS    = 1'b1,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input logic          clk,
  input logic          rst_n,
  reg_file_wb_if.slave bus
);
  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0]  wen;
  logic [DATA_W-1:0] regs_reg [DEPTH];
  logic [31:0]       wr_count_reg;
  logic              commit;
  logic              fwd_a;
  logic              fwd_b;

  wr_decoder_5_32 #(.ADDR_W(ADDR_W)) u_dec (
    .en  (bus.RegWr),
    .idx (bus.rw),
    .wen (wen)
  );

  // Bit 0 of wen is always low, so any set bit is a committed write.
  assign commit = |wen;

  // Entry 0 is reset to zero and never enabled, so it stays a constant zero
  // and every read port can index the array directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_reg[0] <= '0;
      for (int i = 1; i < DEPTH; i++) begin
        regs_reg[i] <= RESET_VAL;
      end
    end else begin
      for (int i = 1; i < DEPTH; i++) begin
        if (wen[i]) begin
          regs_reg[i] <= bus.busW;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_count_reg <= '0;
    end else if (commit) begin
      wr_count_reg <= wr_count_reg + 32'd1;
    end
  end

  // Forwarding reuses the decoded enable, which already excludes register 0.
  // It is also suppressed while reset is held so the read ports show the
  // reset contents rather than a write that will never commit.
  assign fwd_a = BYPASS && rst_n && wen[bus.ra];
  assign fwd_b = BYPASS && rst_n && wen[bus.rb];

  assign bus.busA     = fwd_a ? bus.busW : regs_reg[bus.ra];
  assign bus.busB     = fwd_b ? bus.busW : regs_reg[bus.rb];
  assign bus.dbg_data = regs_reg[bus.dbg_addr];
  assign bus.wr_count = wr_count_reg;

`ifndef SYNTHESIS
  // An unknown write enable would silently skip or corrupt a write.
  a_regwr_known: assert property (@(posedge clk) disable iff (!rst_n)
    !$isunknown(bus.RegWr));
`endif
endmodule

// File: tb/tb_reg_file_wb.sv
module tb_reg_file_wb;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        reg_wr = 1'b0;
  logic [4:0]  rw = '0;
  logic [31:0] bus_w = '0;
  logic [4:0]  ra = '0;
  logic [4:0]  rb = '0;
  logic [4:0]  dbg_addr = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // bus_f: BYPASS = 1, bus_n: BYPASS = 0; both see identical stimulus.
  reg_file_wb_if bus_f ();
  reg_file_wb_if bus_n ();

  assign bus_f.RegWr = reg_wr;  assign bus_n.RegWr = reg_wr;
  assign bus_f.rw = rw;         assign bus_n.rw = rw;
  assign bus_f.busW = bus_w;    assign bus_n.busW = bus_w;
  assign bus_f.ra = ra;         assign bus_n.ra = ra;
  assign bus_f.rb = rb;         assign bus_n.rb = rb;
  assign bus_f.dbg_addr = dbg_addr;
  assign bus_n.dbg_addr = dbg_addr;

  reg_file_wb #(.BYPASS(1'b1)) dut_f (.clk(clk), .rst_n(rst_n), .bus(bus_f.slave));
  reg_file_wb #(.BYPASS(1'b0)) dut_n (.clk(clk), .rst_n(rst_n), .bus(bus_n.slave));

  typedef struct {
    logic        wr;
    logic [4:0]  rw;
    logic [31:0] busw;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [31:0] exp_a;    // busA before the edge (bypass DUT)
    logic [31:0] exp_b;    // busB before the edge (bypass DUT)
    logic [31:0] exp_cnt;  // wr_count after the edge
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end else begin
      $display("ok   %s value=%h", name, act);
    end
  endtask

  // Inputs change 2 time units after the rising edge; outputs are sampled
  // 1 unit after that, well clear of the next edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    // rw=5 bypassed on A; rw=31 bypassed on B; idle; reg 8 = 1; then four
    // edges of RegWr=0 toward reg 3 which must change nothing.
    vecs[0] = '{1'b1, 5'd5,  32'h12345678, 5'd5, 5'd31, 32'h12345678, 32'h0,        32'd1};
    vecs[1] = '{1'b1, 5'd31, 32'hFFFFFFFF, 5'd5, 5'd31, 32'h12345678, 32'hFFFFFFFF, 32'd2};
    vecs[2] = '{1'b0, 5'd0,  32'h0,        5'd5, 5'd31, 32'h12345678, 32'hFFFFFFFF, 32'd2};
    vecs[3] = '{1'b1, 5'd8,  32'h1,        5'd8, 5'd0,  32'h1,        32'h0,        32'd3};
    vecs[4] = '{1'b0, 5'd3,  32'h55,       5'd3, 5'd8,  32'h0,        32'h1,        32'd3};
    vecs[5] = '{1'b0, 5'd3,  32'h55,       5'd3, 5'd8,  32'h0,        32'h1,        32'd3};
    vecs[6] = '{1'b0, 5'd3,  32'h55,       5'd3, 5'd8,  32'h0,        32'h1,        32'd3};
    vecs[7] = '{1'b0, 5'd3,  32'h55,       5'd3, 5'd8,  32'h0,        32'h1,        32'd3};
    vecs[8] = '{1'b0, 5'd0,  32'h0,        5'd3, 5'd3,  32'h0,        32'h0,        32'd3};

    // 1. Reset, zero register.
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i);
      #1 chk($sformatf("reset_dbg[%0d]", i), bus_f.dbg_data, 32'h0);
    end
    chk("reset_cnt", bus_f.wr_count, 32'd0);
    tick();
    reg_wr = 1'b1; rw = 5'd0; bus_w = 32'hDEADBEEF; ra = 5'd0; dbg_addr = 5'd0;
    #1 chk("r0_no_bypass", bus_f.busA, 32'h0);
    tick();
    reg_wr = 1'b0;
    #1 chk("r0_dbg", bus_f.dbg_data, 32'h0);
    chk("r0_cnt", bus_f.wr_count, 32'd0);

    // 2 and 4. Table-driven write/read and enable gating.
    for (int v = 0; v < 9; v++) begin
      reg_wr = vecs[v].wr; rw = vecs[v].rw; bus_w = vecs[v].busw;
      ra = vecs[v].ra; rb = vecs[v].rb;
      #1;
      chk($sformatf("vec%0d_busA", v), bus_f.busA, vecs[v].exp_a);
      chk($sformatf("vec%0d_busB", v), bus_f.busB, vecs[v].exp_b);
      tick();
      chk($sformatf("vec%0d_cnt", v), bus_f.wr_count, vecs[v].exp_cnt);
    end
    dbg_addr = 5'd3;
    #1 chk("gate_reg3", bus_f.dbg_data, 32'h0);

    // 3. Bypass versus no bypass on reg 8 (holds 1).
    tick();
    reg_wr = 1'b1; rw = 5'd8; bus_w = 32'hA5A5A5A5; ra = 5'd8; rb = 5'd8; dbg_addr = 5'd8;
    #1;
    chk("byp_busA", bus_f.busA, 32'hA5A5A5A5);
    chk("byp_busB", bus_f.busB, 32'hA5A5A5A5);
    chk("byp_dbg_pre", bus_f.dbg_data, 32'h1);
    chk("nobyp_busA_pre", bus_n.busA, 32'h1);
    chk("nobyp_busB_pre", bus_n.busB, 32'h1);
    tick();
    reg_wr = 1'b0;
    #1;
    chk("byp_dbg_post", bus_f.dbg_data, 32'hA5A5A5A5);
    chk("nobyp_busA_post", bus_n.busA, 32'hA5A5A5A5);
    chk("cnt_after_byp", bus_f.wr_count, 32'd4);
    chk("nobyp_cnt", bus_n.wr_count, 32'd4);

    // 5. Asynchronous reset mid-operation.
    tick();
    reg_wr = 1'b1; rw = 5'd10; bus_w = 32'h77; dbg_addr = 5'd10; ra = 5'd10;
    tick();
    bus_w = 32'h99;
    #1 chk("pre_rst_reg10", bus_f.dbg_data, 32'h77);
    chk("pre_rst_cnt", bus_f.wr_count, 32'd5);
    rst_n = 1'b0;
    #1;
    chk("async_reg10", bus_f.dbg_data, 32'h0);
    chk("async_busA", bus_f.busA, 32'h0);
    chk("async_cnt", bus_f.wr_count, 32'd0);
    tick();
    chk("held_reg10", bus_f.dbg_data, 32'h0);
    chk("held_cnt", bus_f.wr_count, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_reg10", bus_f.dbg_data, 32'h99);
    chk("post_rst_cnt", bus_f.wr_count, 32'd1);

    // 6. Exhaustive decode after a fresh reset.
    reg_wr = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 1; i < 32; i++) begin
      reg_wr = 1'b1; rw = 5'(i); bus_w = 32'(i) + 32'h100;
      tick();
    end
    reg_wr = 1'b0;
    for (int i = 1; i < 32; i++) begin
      dbg_addr = 5'(i);
      #1 chk($sformatf("decode_reg[%0d]", i), bus_f.dbg_data, 32'(i) + 32'h100);
    end
    chk("decode_cnt", bus_f.wr_count, 32'd31);
    chk("decode_cnt_nobyp", bus_n.wr_count, 32'd31);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
